// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU as a 32-step radix-2 sequential operation and
// accepts MTHI/MTLO writes while idle.
//
// Ports:
//   Clk, Rst_n          clock (rising edge) and asynchronous active-low reset
//   Start, Op           launch an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   OperandA, OperandB  rs / rt values (multiplicand/dividend, multiplier/divisor)
//   HiWrite, LoWrite    load Hi / Lo from OperandA while idle and not starting
//   Busy                operation in progress
//   Done                one-cycle pulse when Hi/Lo hold a new result
//   DivZero             one-cycle pulse with Done for a divide by zero
//   Hi, Lo              HI / LO registers
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 res_neg_q, res_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 b_zero_q, b_zero_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem;

    always_comb begin
        // Only the signed ops (Op[0]=0) take magnitudes.
        a_neg = OperandA[WIDTH-1] & ~Op[0];
        b_neg = OperandB[WIDTH-1] & ~Op[0];
        a_mag = a_neg ? -OperandA : OperandA;
        b_mag = b_neg ? -OperandB : OperandB;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        // Divide: acc = {partial remainder, dividend bits / quotient bits}.
        // The remainder stays below the divisor, so the shifted value needs one extra bit.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = (div_shift >= {1'b0, opnd_q})
                  ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                  : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

        prod = res_neg_q ? -acc_q : acc_q;
        quot = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        b_zero_d   = b_zero_q;
        opnd_d     = opnd_q;
        orig_a_d   = orig_a_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d   = StRun;
                    busy_d    = 1'b1;
                    cnt_d     = CntW'(WIDTH - 1);
                    is_div_d  = Op[1];
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    b_zero_d  = (OperandB == '0);
                    orig_a_d  = OperandA;
                    if (Op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end else begin
                    if (HiWrite) hi_d = OperandA;
                    if (LoWrite) lo_d = OperandA;
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFinish;
            end
            StFinish: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_zero_q) begin
                    hi_d       = orig_a_q;
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            opnd_q     <= '0;
            orig_a_q   <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            b_zero_q   <= b_zero_d;
            opnd_q     <= opnd_d;
            orig_a_q   <= orig_a_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = div_zero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        HiWrite;
    logic        LoWrite;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Op       (Op),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .HiWrite  (HiWrite),
        .LoWrite  (LoWrite),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Launch at a falling edge, follow Busy to Done and check the result.
    // lw: assert LoWrite with Start; disturb: hammer Start/HiWrite/LoWrite while busy.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic lw, input logic disturb,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int          busy_cnt;
        logic [31:0] lo_before;
        lo_before = Lo;
        Start     = 1'b1;
        Op        = op;
        OperandA  = a;
        OperandB  = b;
        LoWrite   = lw;
        @(negedge Clk);
        Start   = 1'b0;
        LoWrite = 1'b0;
        if (lw) chk({tag, " lo_kept_on_start"}, Lo, lo_before);
        busy_cnt = 0;
        while (Busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (disturb) begin
                Start    = 1'b1;
                HiWrite  = 1'b1;
                LoWrite  = 1'b1;
                OperandA = 32'h1234;
            end
            @(negedge Clk);
        end
        Start   = 1'b0;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
        chk({tag, " done"}, {31'b0, Done}, 32'd1);
        chk({tag, " divzero"}, {31'b0, DivZero}, {31'b0, exp_dz});
        chk({tag, " hi"}, Hi, exp_hi);
        chk({tag, " lo"}, Lo, exp_lo);
    endtask

    initial begin
        int done_seen;
        Rst_n    = 1'b0;
        Start    = 1'b0;
        Op       = 2'b00;
        OperandA = '0;
        OperandB = '0;
        HiWrite  = 1'b0;
        LoWrite  = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset hi", Hi, 32'd0);
        chk("reset lo", Lo, 32'd0);
        chk("reset busy", {31'b0, Busy}, 32'd0);
        chk("reset done", {31'b0, Done}, 32'd0);
        chk("reset divzero", {31'b0, DivZero}, 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge Clk);
        chk("multu_max done_pulse_ends", {31'b0, Done}, 32'd0);

        // Reset during cycle 10 of a MULT: everything clears at once, no Done.
        Start    = 1'b1;
        Op       = 2'b00;
        OperandA = 32'd3;
        OperandB = 32'd5;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("midrun_reset busy", {31'b0, Busy}, 32'd0);
        chk("midrun_reset hi", Hi, 32'd0);
        chk("midrun_reset lo", Lo, 32'd0);
        chk("midrun_reset done", {31'b0, Done}, 32'd0);
        @(negedge Clk);
        Rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) done_seen++;
        end
        chk("midrun_reset no_done", 32'(done_seen), 32'd0);
        chk("midrun_reset lo_stays", Lo, 32'd0);

        run_op("mult_neg7x3", 2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7byneg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0,
               32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100by0", 2'b11, 32'd100, 32'd0, 1'b0, 1'b0,
               32'd100, 32'hFFFF_FFFF, 1'b1);
        @(negedge Clk);
        chk("divu_100by0 divzero_pulse_ends", {31'b0, DivZero}, 32'd0);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0,
               32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'd0, 32'h8000_0000, 1'b0);

        // Writes and Start pulses during Busy must have no effect.
        run_op("multu_disturbed", 2'b01, 32'd5, 32'd6, 1'b0, 1'b1,
               32'd0, 32'd30, 1'b0);
        @(negedge Clk);
        chk("multu_disturbed no_extra_done", {31'b0, Done}, 32'd0);
        chk("multu_disturbed no_restart", {31'b0, Busy}, 32'd0);

        HiWrite  = 1'b1;
        LoWrite  = 1'b1;
        OperandA = 32'h0000_ABCD;
        @(negedge Clk);
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        chk("mthi_mtlo hi", Hi, 32'h0000_ABCD);
        chk("mthi_mtlo lo", Lo, 32'h0000_ABCD);

        run_op("start_with_lowrite", 2'b01, 32'd2, 32'd3, 1'b1, 1'b0,
               32'd0, 32'd6, 1'b0);
        // Back-to-back: each Start lands in the previous Done cycle.
        run_op("b2b_divu", 2'b11, 32'd1000, 32'd7, 1'b0, 1'b0,
               32'd6, 32'd142, 1'b0);
        run_op("b2b_mult", 2'b00, 32'h0001_0000, 32'hFFFF_0000, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
